ctrl_decode_stage: RTL and testbench

Registered, parametrised decode/control stage between fetch and execute.
- Decodes the 4-bit-class opcode set into the EX control bundle.
- Adds valid/ready flow control, a load-use hazard bubble, a multi-cycle wrong-path squash after a taken branch, illegal-opcode trapping, and saturating stall/flush event counters.

---
 rtl/ctrl_decode_if.sv | 48 ++++
 rtl/ctrl_decode_stage.sv | 159 +++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_decode_if.sv
// ctrl_decode_if: fetch-side handshake and EX-side control bundle of the
// decode stage, grouped so the stage and its neighbours share one bundle.
//   master : drives i_* (fetch instruction, EX branch result, counter clear),
//            observes o_*.
//   slave  : the decode stage; observes i_*, drives o_*.
interface ctrl_decode_if #(
  parameter int OPCODE_W  = 4,
  parameter int RA_W      = 4,
  parameter int ALUFUNC_W = 2,
  parameter int CNT_W     = 8
);
  logic                 i_valid;
  logic [OPCODE_W-1:0]  i_opcode;
  logic [RA_W-1:0]      i_src_a;
  logic [RA_W-1:0]      i_src_b;
  logic [RA_W-1:0]      i_dst;
  logic                 i_br_taken;
  logic                 i_cnt_clr;
  logic                 o_ready;
  logic                 o_valid;
  logic [ALUFUNC_W-1:0] o_alufunc;
  logic                 o_branch;
  logic                 o_flush;
  logic                 o_regwrite;
  logic                 o_memwrite;
  logic                 o_memtoreg;
  logic                 o_immediate;
  logic                 o_forward;
  logic [RA_W-1:0]      o_dst;
  logic                 o_squash;
  logic                 o_illegal;
  logic [CNT_W-1:0]     o_stall_cnt;
  logic [CNT_W-1:0]     o_flush_cnt;

  modport master (
    output i_valid, i_opcode, i_src_a, i_src_b, i_dst, i_br_taken, i_cnt_clr,
    input  o_ready, o_valid, o_alufunc, o_branch, o_flush, o_regwrite,
           o_memwrite, o_memtoreg, o_immediate, o_forward, o_dst, o_squash,
           o_illegal, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_valid, i_opcode, i_src_a, i_src_b, i_dst, i_br_taken, i_cnt_clr,
    output o_ready, o_valid, o_alufunc, o_branch, o_flush, o_regwrite,
           o_memwrite, o_memtoreg, o_immediate, o_forward, o_dst, o_squash,
           o_illegal, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered decode/control stage between fetch and EX.
// Decodes the opcode into the EX control bundle with valid/ready flow
// control, a one-bubble load-use stall, a FLUSH_CYCLES-long wrong-path squash
// after a taken branch, sticky illegal-opcode trap and saturating counters.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : ctrl_decode_if.slave (fetch inputs, branch result, counter
//             clear, ready, registered EX bundle, squash, illegal, counters)
module ctrl_decode_stage #(
  parameter int OPCODE_W     = 4,
  parameter int RA_W         = 4,
  parameter int ALUFUNC_W    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  ctrl_decode_if.slave bus
);

  localparam int SQ_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic [1:0] alu;
    logic       branch;
    logic       flush;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       immediate;
    logic       forward;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OPCODE_W'(0):  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.immediate = 1'b1; c.forward = 1'b1; end
      OPCODE_W'(1):  begin c.memwrite = 1'b1; c.immediate = 1'b1; end
      OPCODE_W'(2):  begin c.regwrite = 1'b1; c.forward = 1'b1; c.alu = 2'b00; end
      OPCODE_W'(3):  begin c.regwrite = 1'b1; c.forward = 1'b1; c.alu = 2'b01; end
      OPCODE_W'(4):  begin c.regwrite = 1'b1; c.forward = 1'b1; c.alu = 2'b10; end
      OPCODE_W'(5):  begin c.regwrite = 1'b1; c.forward = 1'b1; c.alu = 2'b11; end
      OPCODE_W'(6):  begin c.regwrite = 1'b1; c.immediate = 1'b1; c.forward = 1'b1; c.alu = 2'b00; end
      OPCODE_W'(7):  begin c.regwrite = 1'b1; c.immediate = 1'b1; c.forward = 1'b1; c.alu = 2'b01; end
      OPCODE_W'(8):  begin c.regwrite = 1'b1; c.immediate = 1'b1; c.forward = 1'b1; c.alu = 2'b10; end
      OPCODE_W'(9):  begin c.branch = 1'b1; c.flush = 1'b1; c.immediate = 1'b1; c.alu = 2'b01; end
      OPCODE_W'(10): begin c.branch = 1'b1; c.flush = 1'b1; c.alu = 2'b01; end
      default:       c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_src_b(input logic [OPCODE_W-1:0] op);
    return ((op >= OPCODE_W'(2)) && (op <= OPCODE_W'(5))) || (op == OPCODE_W'(10));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [SQ_W-1:0]  sq_q, sq_d;
  logic             vld_q, vld_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [RA_W-1:0]  dst_q, dst_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flushc_q, flushc_d;

  logic hazard, taken, stall, legal, accept_run, issue, trap;

  always_comb begin
    hazard = vld_q && ctrl_q.memtoreg && bus.i_valid &&
             ((dst_q == bus.i_src_a) ||
              (uses_src_b(bus.i_opcode) && (dst_q == bus.i_src_b)));
    taken  = (state_q == RUN) && vld_q && ctrl_q.branch && bus.i_br_taken;
    // A taken branch wins over a hazard: the presented instruction is
    // wrong-path, so it is consumed and dropped instead of stalled.
    stall  = (state_q == RUN) && hazard && !taken;
    legal  = bus.i_opcode < OPCODE_W'(11);
    accept_run = (state_q == RUN) && !taken && bus.i_valid && !hazard;
    issue  = accept_run && legal;
    trap   = accept_run && !legal;
  end

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    case (state_q)
      RUN: begin
        if (taken) begin
          state_d = FLUSH;
          sq_d    = SQ_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        sq_d = sq_q - SQ_W'(1);
        if (sq_q == SQ_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    vld_d  = issue;
    ctrl_d = issue ? decode(bus.i_opcode) : '0;
    dst_d  = issue ? bus.i_dst : dst_q;

    illegal_d = illegal_q | trap;
    stall_d   = stall ? sat_inc(stall_q) : stall_q;
    flushc_d  = taken ? sat_inc(flushc_q) : flushc_q;
    if (bus.i_cnt_clr) begin
      illegal_d = 1'b0;
      stall_d   = '0;
      flushc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      sq_q      <= '0;
      vld_q     <= 1'b0;
      ctrl_q    <= '0;
      dst_q     <= '0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
      flushc_q  <= '0;
    end else begin
      state_q   <= state_d;
      sq_q      <= sq_d;
      vld_q     <= vld_d;
      ctrl_q    <= ctrl_d;
      dst_q     <= dst_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
      flushc_q  <= flushc_d;
    end
  end

  assign bus.o_ready     = !stall;
  assign bus.o_valid     = vld_q;
  assign bus.o_alufunc   = ALUFUNC_W'(ctrl_q.alu);
  assign bus.o_branch    = ctrl_q.branch;
  assign bus.o_flush     = ctrl_q.flush;
  assign bus.o_regwrite  = ctrl_q.regwrite;
  assign bus.o_memwrite  = ctrl_q.memwrite;
  assign bus.o_memtoreg  = ctrl_q.memtoreg;
  assign bus.o_immediate = ctrl_q.immediate;
  assign bus.o_forward   = ctrl_q.forward;
  assign bus.o_dst       = dst_q;
  assign bus.o_squash    = (state_q == FLUSH);
  assign bus.o_illegal   = illegal_q;
  assign bus.o_stall_cnt = stall_q;
  assign bus.o_flush_cnt = flushc_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenarios followed by random traffic,
// every output compared each cycle against a table-driven reference model.
module tb_ctrl_decode_stage;
  localparam int OPCODE_W     = 4;
  localparam int RA_W         = 4;
  localparam int ALUFUNC_W    = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 2;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_decode_if #(.OPCODE_W(OPCODE_W), .RA_W(RA_W), .ALUFUNC_W(ALUFUNC_W),
                   .CNT_W(CNT_W)) bus ();

  ctrl_decode_stage #(.OPCODE_W(OPCODE_W), .RA_W(RA_W), .ALUFUNC_W(ALUFUNC_W),
                      .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control word layout: {alu[1:0], branch, flush, regwrite, memwrite,
  // memtoreg, immediate, forward}
  logic [8:0] dec_tbl [0:10];
  initial begin
    dec_tbl[0]  = {2'b00, 7'b0010111};
    dec_tbl[1]  = {2'b00, 7'b0001010};
    for (int k = 0; k < 4; k++) dec_tbl[2+k] = {2'(k), 7'b0010001};
    for (int k = 0; k < 3; k++) dec_tbl[6+k] = {2'(k), 7'b0010011};
    dec_tbl[9]  = {2'b01, 7'b1100010};
    dec_tbl[10] = {2'b01, 7'b1100000};
  end

  // Reference model state
  int             m_left;
  bit             m_valid;
  logic [8:0]     m_ctrl;
  logic [RA_W-1:0] m_dst;
  bit             m_ill;
  int             m_stall, m_flush;

  task automatic model_reset();
    m_left = 0; m_valid = 0; m_ctrl = '0; m_dst = '0;
    m_ill = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic bit reads_b(input int op);
    return (op >= 2 && op <= 5) || op == 10;
  endfunction

  function automatic bit m_hazard();
    return m_valid && m_ctrl[2] && bus.i_valid &&
           (m_dst == bus.i_src_a || (reads_b(int'(bus.i_opcode)) && m_dst == bus.i_src_b));
  endfunction

  function automatic bit m_taken();
    return m_left == 0 && m_valid && m_ctrl[6] && bus.i_br_taken;
  endfunction

  function automatic bit m_ready();
    return m_left > 0 || m_taken() || !m_hazard();
  endfunction

  task automatic check_outputs();
    logic [8:0] ctrl_obs;
    ctrl_obs = {bus.o_alufunc[1:0], bus.o_branch, bus.o_flush, bus.o_regwrite,
                bus.o_memwrite, bus.o_memtoreg, bus.o_immediate, bus.o_forward};
    check_eq("ready",  32'(bus.o_ready), 32'(m_ready()));
    check_eq("valid",  32'(bus.o_valid), 32'(m_valid));
    check_eq("ctrl",   32'(ctrl_obs), 32'(m_ctrl));
    check_eq("dst",    32'(bus.o_dst), 32'(m_dst));
    check_eq("squash", 32'(bus.o_squash), 32'(m_left > 0));
    check_eq("illegal", 32'(bus.o_illegal), 32'(m_ill));
    check_eq("stall_cnt", 32'(bus.o_stall_cnt), 32'(m_stall));
    check_eq("flush_cnt", 32'(bus.o_flush_cnt), 32'(m_flush));
  endtask

  // One clock: check at the falling edge, advance model over the rising edge.
  task automatic cycle(output bit accepted);
    int n_left, n_stall, n_flush, op;
    bit n_valid, n_ill;
    logic [8:0] n_ctrl;
    logic [RA_W-1:0] n_dst;
    @(negedge clk);
    check_outputs();
    accepted = bus.i_valid && m_ready();
    op = int'(bus.i_opcode);
    n_left = m_left; n_stall = m_stall; n_flush = m_flush; n_ill = m_ill;
    n_valid = 0; n_ctrl = '0; n_dst = m_dst;
    if (m_left > 0) n_left = m_left - 1;
    else if (m_taken()) begin
      n_left = FLUSH_CYCLES;
      n_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    end else if (!bus.i_valid) begin
    end else if (m_hazard()) n_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    else if (op > 10) n_ill = 1;
    else begin
      n_valid = 1; n_ctrl = dec_tbl[op]; n_dst = bus.i_dst;
    end
    if (bus.i_cnt_clr) begin n_stall = 0; n_flush = 0; n_ill = 0; end
    @(posedge clk);
    #1;
    if (reset_n) begin
      m_left = n_left; m_valid = n_valid; m_ctrl = n_ctrl; m_dst = n_dst;
      m_ill = n_ill; m_stall = n_stall; m_flush = n_flush;
    end else model_reset();
  endtask

  task automatic set_in(input bit v, input int op, input int a, input int b,
                        input int d, input bit br, input bit clr);
    bus.i_valid = v; bus.i_opcode = OPCODE_W'(op);
    bus.i_src_a = RA_W'(a); bus.i_src_b = RA_W'(b); bus.i_dst = RA_W'(d);
    bus.i_br_taken = br; bus.i_cnt_clr = clr;
  endtask

  // Present an instruction until the stage takes it (bounded).
  task automatic present(input int op, input int a, input int b, input int d,
                         input bit br, input bit clr);
    bit acc;
    int tries;
    set_in(1'b1, op, a, b, d, br, clr);
    tries = 0;
    acc = 0;
    while (!acc && tries < 8) begin
      cycle(acc);
      bus.i_cnt_clr = 1'b0;
      tries++;
    end
    if (!acc) check_eq("accept_timeout", 32'(tries), 32'(0));
  endtask

  task automatic idle(input int n);
    bit acc;
    set_in(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) cycle(acc);
  endtask

  initial begin
    bit acc, have;
    model_reset();
    set_in(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    reset_n = 1'b0;
    cycle(acc);
    cycle(acc);
    reset_n = 1'b1;

    // Full decode table, back to back, distinct registers
    for (int op = 0; op <= 10; op++) present(op, op, (op + 5) % 16, 15 - op, 1'b0, 1'b0);
    idle(2);

    // Load-use via src_b, then IMM_add whose src_b is not read
    present(0, 1, 1, 3, 1'b0, 1'b0);
    present(2, 1, 3, 4, 1'b0, 1'b0);
    present(0, 1, 1, 3, 1'b0, 1'b0);
    present(6, 5, 3, 4, 1'b0, 1'b0);
    idle(1);

    // Taken BAF_reg with fetch streaming, then not-taken
    present(10, 1, 2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) present(2 + k, 6, 7, 8 + k, 1'b1, 1'b0);
    present(10, 1, 2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) present(6 + k, 6, 7, 8 + k, 1'b0, 1'b0);
    idle(1);

    // Illegal opcode, then clear alongside a hazard
    present(13, 0, 0, 0, 1'b0, 1'b0);
    idle(2);
    present(0, 1, 1, 3, 1'b0, 1'b0);
    present(2, 3, 0, 4, 1'b0, 1'b1);
    idle(1);

    // Five load-use hazards saturate the stall counter
    for (int k = 0; k < 5; k++) begin
      present(0, 1, 1, 2, 1'b0, 1'b0);
      present(3, 2, 9, 5, 1'b0, 1'b0);
    end
    idle(1);

    // Reset in the middle of FLUSH
    present(9, 1, 1, 0, 1'b0, 1'b0);
    present(2, 1, 1, 1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_squash", 32'(bus.o_squash), 32'(0));
    check_eq("rst_valid",  32'(bus.o_valid), 32'(0));
    set_in(1'b1, 2, 1, 1, 1, 1'b0, 1'b0);
    cycle(acc);
    reset_n = 1'b1;
    idle(1);

    // Random traffic; fetch holds an instruction until it is taken
    have = 0;
    for (int it = 0; it < 3000; it++) begin
      if (!have) begin
        set_in($urandom_range(0, 9) != 0, $urandom_range(0, 15),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'b0, 1'b0);
        have = 1;
      end
      bus.i_br_taken = $urandom_range(0, 1) != 0;
      bus.i_cnt_clr  = $urandom_range(0, 39) == 0;
      cycle(acc);
      if (acc || !bus.i_valid) have = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
